// File: rtl/ram_reader.sv
// ram_reader: walks an inclusive, wrapping address range of a sync RAM and streams each word over valid/ready
module ram_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {idle, issue, wait_q, present} state_t;
    state_t state, next;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic done_n;
    logic go;
    logic xfer;
    logic last;
    assign go   = start && !abort;
    assign xfer = out_ready && !abort;
    assign last = ram_address == end_addr;
    // state register
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= idle;
        else state <= next;
    // next state and completion pulse; abort always wins
    always_comb begin
        next   = state;
        done_n = 1'b0;
        unique case (state)
            idle:    next = go ? issue : idle;
            issue:   next = abort ? idle : wait_q;
            wait_q:  next = abort ? idle : present;
            present: begin
                next   = abort ? idle : !out_ready ? present : last ? idle : issue;
                done_n = xfer && last;
            end
        endcase
    end
    // datapath: range capture, pointer advance, word capture and registered flags
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            ram_address <= '0;
            end_addr    <= '0;
            out_data    <= '0;
            out_addr    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == idle && go) begin
                ram_address <= first_addr;
                end_addr    <= last_addr;
            end
            if (state == wait_q && !abort) begin
                out_data <= ram_q;
                out_addr <= ram_address;
            end
            if (state == present && xfer && !last) ram_address <= ram_address + ADDR_WIDTH'(1);
            out_valid <= next == present;
            busy      <= next != idle;
            done      <= done_n;
        end
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: randomized scoreboard bench for ram_reader against a range-arithmetic model
module tb_ram_reader;
    logic clock = 0, resetn = 0, start = 0, abort = 0, out_ready = 0;
    logic [3:0] first_addr = 0, last_addr = 0, ram_address, out_addr;
    logic [7:0] ram_q, out_data;
    logic out_valid, busy, done;
    logic [7:0] mem [16];
    int compared = 0, mismatched = 0;
    typedef struct {logic [3:0] a; logic [7:0] d; bit last;} exp_t;
    exp_t sb[$];
    bit exp_done = 0, rand_ready = 0, have_hold = 0;
    logic [11:0] hold;

    ram_reader dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .ram_address(ram_address),
        .ram_q(ram_q), .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // 16x8 synchronous RAM, one-cycle read latency
    always @(posedge clock) ram_q <= mem[ram_address];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // monitor: checks transfers, stall stability and the done pulse
    always @(negedge clock) if (resetn) begin
        exp_t e;
        chk("done", done, exp_done);
        if (exp_done) chk("busy_at_done", busy, 0);
        exp_done = 0;
        if (out_valid) begin
            if (have_hold) chk("stall_hold", {out_addr, out_data}, hold);
            if (out_ready) begin
                have_hold = 0;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got addr %0h data %0h, none expected", out_addr, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("addr", out_addr, e.a);
                    chk("data", out_data, e.d);
                    if (e.last) exp_done = 1;
                end
            end else begin
                have_hold = 1;
                hold = {out_addr, out_data};
            end
        end else have_hold = 0;
    end

    // random backpressure when enabled
    always @(posedge clock) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_scan(logic [3:0] f, logic [3:0] l);
        int n;
        logic [3:0] a;
        n = int'(4'(l - f)) + 1;
        for (int i = 0; i < n; i++) begin
            a = 4'(f + i);
            sb.push_back('{a, mem[a], i == n - 1});
        end
    endtask

    task automatic start_scan(logic [3:0] f, logic [3:0] l);
        first_addr = f;
        last_addr = l;
        start = 1;
        expect_scan(f, l);
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000 && (busy || sb.size() != 0); k++) tick();
        if (k >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: busy %0b, %0d words outstanding, required idle", busy, sb.size());
        end
    endtask

    task automatic chk_reset(string n);
        chk({n, "_ram_address"}, ram_address, 0);
        chk({n, "_out_data"}, out_data, 0);
        chk({n, "_out_addr"}, out_addr, 0);
        chk({n, "_out_valid"}, out_valid, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_done"}, done, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        #12;
        chk_reset("reset");
        resetn = 1;
        tick();
        // single word with latency checks
        mem[5] = 8'hA5;
        out_ready = 1;
        start_scan(5, 5);
        chk("lat_e0_valid", out_valid, 0);
        tick();
        chk("lat_e1_valid", out_valid, 0);
        tick();
        chk("lat_e2_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_addr", out_addr, 5);
        tick();
        chk("single_done", done, 1);
        chk("single_busy", busy, 0);
        wait_idle();
        // wrap-around range
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        start_scan(14, 1);
        wait_idle();
        // full sweep with a stall on word 0
        out_ready = 0;
        start_scan(3, 2);
        for (k = 0; k < 20 && !out_valid; k++) tick();
        repeat (5) tick();
        out_ready = 1;
        wait_idle();
        // abort while the 2nd word is presented
        start_scan(0, 7);
        for (k = 0; k < 50 && sb.size() != 7; k++) tick();
        out_ready = 0;
        for (k = 0; k < 20 && !out_valid; k++) tick();
        chk("abort_pre_valid", out_valid, 1);
        abort = 1;
        tick();
        abort = 0;
        sb.delete();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (3) tick();
        // abort and start together in idle
        out_ready = 1;
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        chk("start_abort_busy", busy, 0);
        // start mid-scan is ignored
        start_scan(2, 5);
        tick();
        tick();
        first_addr = 9;
        last_addr = 12;
        start = 1;
        tick();
        start = 0;
        wait_idle();
        // random scans with random backpressure
        rand_ready = 1;
        repeat (10) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            start_scan(4'($urandom), 4'($urandom));
            wait_idle();
        end
        rand_ready = 0;
        tick();
        // asynchronous reset during WAIT
        out_ready = 1;
        start_scan(4, 6);
        tick();
        #2;
        resetn = 0;
        #1;
        chk_reset("async");
        sb.delete();
        tick();
        resetn = 1;
        tick();
        mem[0] = 8'h3C;
        start_scan(0, 0);
        wait_idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
